// File: rtl/y_calculator.sv
// y_calculator: one CORDIC vectoring-mode Y micro-rotation in IEEE-754 binary32.
// y_out <= (y >= 0) ? y - x_shift : y + x_shift, computed by a combinational
// round-to-nearest-even adder and registered once per clock.
module y_calculator #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] x_shift,
    output logic [WIDTH-1:0] y_out
);

    // Operand fields; operand b is x_shift with its sign flipped when y is non-negative
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [7:0]  eff_a, eff_b;
    logic [23:0] sig_a, sig_b;

    // Ordered by magnitude
    logic        a_big;
    logic        sign_big, sign_small;
    logic [7:0]  exp_big, exp_small;
    logic [23:0] sig_big, sig_small;

    // Alignment: significand plus guard, round, sticky
    logic [7:0]  diff;
    logic [26:0] big_ext, small_ext, mask, aligned;

    // Magnitude sum and normalisation
    logic [27:0] sum;
    logic [26:0] norm;
    logic [9:0]  exp_n;
    logic [4:0]  lzc;
    logic        lz_found;
    logic [9:0]  shamt;

    // Rounding and packing
    logic [23:0] mant;
    logic        round_up;
    logic [24:0] mant_r;
    logic [9:0]  exp_f;
    logic [22:0] frac_f;
    logic [31:0] result;

    // Unpack operands, order them by magnitude and align the smaller one
    always_comb begin
        sign_a = y[31];
        exp_a  = y[30:23];
        frac_a = y[22:0];
        sign_b = x_shift[31] ^ ~y[31];
        exp_b  = x_shift[30:23];
        frac_b = x_shift[22:0];

        nan_a = (exp_a == 8'hFF) && (frac_a != '0);
        nan_b = (exp_b == 8'hFF) && (frac_b != '0);
        inf_a = (exp_a == 8'hFF) && (frac_a == '0);
        inf_b = (exp_b == 8'hFF) && (frac_b == '0);

        // Denormals: hidden bit 0 and effective exponent 1
        eff_a = (exp_a == '0) ? 8'd1 : exp_a;
        eff_b = (exp_b == '0) ? 8'd1 : exp_b;
        sig_a = {(exp_a != '0), frac_a};
        sig_b = {(exp_b != '0), frac_b};

        a_big      = y[30:0] >= x_shift[30:0];
        sign_big   = a_big ? sign_a : sign_b;
        sign_small = a_big ? sign_b : sign_a;
        exp_big    = a_big ? eff_a  : eff_b;
        exp_small  = a_big ? eff_b  : eff_a;
        sig_big    = a_big ? sig_a  : sig_b;
        sig_small  = a_big ? sig_b  : sig_a;

        diff      = exp_big - exp_small;
        big_ext   = {sig_big, 3'b000};
        small_ext = {sig_small, 3'b000};
        mask      = '0;
        if (diff >= 8'd26) begin
            aligned = {26'b0, (sig_small != '0)};
        end else begin
            mask    = (27'd1 << diff) - 27'd1;
            aligned = (small_ext >> diff) | {26'b0, ((small_ext & mask) != '0)};
        end
    end

    // Add or subtract magnitudes and normalise, never below exponent 1
    always_comb begin
        if (sign_big == sign_small) begin
            sum = {1'b0, big_ext} + {1'b0, aligned};
        end else begin
            sum = {1'b0, big_ext} - {1'b0, aligned};
        end

        lzc      = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!lz_found && sum[26 - i]) begin
                lzc      = 5'(i);
                lz_found = 1'b1;
            end
        end

        exp_n = {2'b00, exp_big};
        shamt = '0;
        if (sum[27]) begin
            // Carry-out: shift right one place, folding the dropped bit into sticky
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            shamt = ({5'b0, lzc} > (exp_n - 10'd1)) ? (exp_n - 10'd1) : {5'b0, lzc};
            norm  = sum[26:0] << shamt;
            exp_n = exp_n - shamt;
        end
    end

    // Round to nearest even, then resolve special cases and pack
    always_comb begin
        mant     = norm[26:3];
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, mant} + {24'b0, round_up};

        // A denormal that rounds up into the hidden bit becomes the smallest normal
        if (mant_r[24]) begin
            exp_f  = exp_n + 10'd1;
            frac_f = mant_r[23:1];
        end else if (mant_r[23]) begin
            exp_f  = exp_n;
            frac_f = mant_r[22:0];
        end else begin
            exp_f  = '0;
            frac_f = mant_r[22:0];
        end

        if (nan_a || nan_b) begin
            result = 32'h7FC00000;
        end else if (inf_a && inf_b) begin
            result = (sign_a != sign_b) ? 32'h7FC00000 : {sign_a, 8'hFF, 23'b0};
        end else if (inf_a) begin
            result = {sign_a, 8'hFF, 23'b0};
        end else if (inf_b) begin
            result = {sign_b, 8'hFF, 23'b0};
        end else if (sum == '0) begin
            result = {sign_a & sign_b, 31'b0};
        end else if (exp_f >= 10'd255) begin
            result = {sign_big, 8'hFF, 23'b0};
        end else begin
            result = {sign_big, exp_f[7:0], frac_f};
        end
    end

    // Output register with synchronous reset taking priority
    always_ff @(posedge clock) begin
        if (reset) begin
            y_out <= '0;
        end else begin
            y_out <= result;
        end
    end

endmodule

// File: tb/tb_y_calculator.sv
// Directed self-checking bench for y_calculator with hand-computed expectations.
module tb_y_calculator;

    logic        clock;
    logic        reset;
    logic [31:0] y;
    logic [31:0] x_shift;
    logic [31:0] y_out;

    int unsigned passed;
    int unsigned total;

    logic [31:0] vy   [0:3];
    logic [31:0] vx   [0:3];
    logic [31:0] vexp [0:3];

    y_calculator #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .y       (y),
        .x_shift (x_shift),
        .y_out   (y_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a vector, let one rising edge capture it, sample 1 time unit later
    task automatic apply(input logic [31:0] yv, input logic [31:0] xv);
        y       = yv;
        x_shift = xv;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        apply(32'h3F800000, 32'h3F000000);
        total++;
        if (y_out !== 32'h00000000) $display("FAIL reset_edge1 got %h want %h", y_out, 32'h00000000);
        else passed++;
        apply(32'h12345678, 32'h9ABCDEF0);
        total++;
        if (y_out !== 32'h00000000) $display("FAIL reset_edge2 got %h want %h", y_out, 32'h00000000);
        else passed++;
        reset = 1'b0;
        apply(32'h3F800000, 32'h3F000000);
        total++;
        if (y_out !== 32'h3F000000) $display("FAIL reset_release got %h want %h", y_out, 32'h3F000000);
        else passed++;
        // Mid-stream reset discards the pending result
        reset = 1'b1;
        apply(32'hC0000000, 32'h3F800000);
        total++;
        if (y_out !== 32'h00000000) $display("FAIL reset_midstream got %h want %h", y_out, 32'h00000000);
        else passed++;
        reset = 1'b0;
        apply(32'hC0000000, 32'h3F800000);
        total++;
        if (y_out !== 32'hBF800000) $display("FAIL reset_resume got %h want %h", y_out, 32'hBF800000);
        else passed++;
    endtask

    task automatic test_rounding;
        apply(32'h30000000, 32'h0A000000);
        total++;
        if (y_out !== 32'h30000000) $display("FAIL rne_tiny_sub got %h want %h", y_out, 32'h30000000);
        else passed++;
        apply(32'hA1000000, 32'h4A000005);
        total++;
        if (y_out !== 32'h4A000005) $display("FAIL rne_tiny_add got %h want %h", y_out, 32'h4A000005);
        else passed++;
    endtask

    task automatic test_denormal;
        apply(32'h026E8B75, 32'h00000003);
        total++;
        if (y_out !== 32'h026E8B75) $display("FAIL denorm_normal got %h want %h", y_out, 32'h026E8B75);
        else passed++;
        apply(32'h00000003, 32'h00000001);
        total++;
        if (y_out !== 32'h00000002) $display("FAIL denorm_denorm got %h want %h", y_out, 32'h00000002);
        else passed++;
        apply(32'h007FFFFF, 32'h80000001);
        total++;
        if (y_out !== 32'h00800000) $display("FAIL denorm_to_normal got %h want %h", y_out, 32'h00800000);
        else passed++;
    endtask

    task automatic test_basic;
        apply(32'h3F800000, 32'h3F000000);
        total++;
        if (y_out !== 32'h3F000000) $display("FAIL sub_one_half got %h want %h", y_out, 32'h3F000000);
        else passed++;
        apply(32'hC0000000, 32'h3F800000);
        total++;
        if (y_out !== 32'hBF800000) $display("FAIL add_neg_two got %h want %h", y_out, 32'hBF800000);
        else passed++;
    endtask

    task automatic test_cancel;
        apply(32'h3F800000, 32'h3F800000);
        total++;
        if (y_out !== 32'h00000000) $display("FAIL cancel_exact got %h want %h", y_out, 32'h00000000);
        else passed++;
        apply(32'h00000000, 32'h3F800000);
        total++;
        if (y_out !== 32'hBF800000) $display("FAIL pos_zero_sub got %h want %h", y_out, 32'hBF800000);
        else passed++;
        apply(32'h80000000, 32'h3F800000);
        total++;
        if (y_out !== 32'h3F800000) $display("FAIL neg_zero_add got %h want %h", y_out, 32'h3F800000);
        else passed++;
        apply(32'h00000000, 32'h00000000);
        total++;
        if (y_out !== 32'h00000000) $display("FAIL all_zero got %h want %h", y_out, 32'h00000000);
        else passed++;
        apply(32'h80000000, 32'h80000000);
        total++;
        if (y_out !== 32'h80000000) $display("FAIL neg_zero_sum got %h want %h", y_out, 32'h80000000);
        else passed++;
    endtask

    task automatic test_specials;
        apply(32'h7F7FFFFF, 32'hFF7FFFFF);
        total++;
        if (y_out !== 32'h7F800000) $display("FAIL overflow_inf got %h want %h", y_out, 32'h7F800000);
        else passed++;
        apply(32'h7FC00000, 32'h3F800000);
        total++;
        if (y_out !== 32'h7FC00000) $display("FAIL nan_y got %h want %h", y_out, 32'h7FC00000);
        else passed++;
        apply(32'h3F800000, 32'h7FA00001);
        total++;
        if (y_out !== 32'h7FC00000) $display("FAIL nan_x got %h want %h", y_out, 32'h7FC00000);
        else passed++;
        apply(32'h7F800000, 32'h7F800000);
        total++;
        if (y_out !== 32'h7FC00000) $display("FAIL inf_minus_inf got %h want %h", y_out, 32'h7FC00000);
        else passed++;
        apply(32'hFF800000, 32'h3F800000);
        total++;
        if (y_out !== 32'hFF800000) $display("FAIL neg_inf_finite got %h want %h", y_out, 32'hFF800000);
        else passed++;
        apply(32'h3F800000, 32'h7F800000);
        total++;
        if (y_out !== 32'hFF800000) $display("FAIL finite_minus_inf got %h want %h", y_out, 32'hFF800000);
        else passed++;
    endtask

    task automatic test_back_to_back;
        vy[0] = 32'h3F800000; vx[0] = 32'h3F000000; vexp[0] = 32'h3F000000;
        vy[1] = 32'hC0000000; vx[1] = 32'h3F800000; vexp[1] = 32'hBF800000;
        vy[2] = 32'h30000000; vx[2] = 32'h0A000000; vexp[2] = 32'h30000000;
        vy[3] = 32'h80000000; vx[3] = 32'h3F800000; vexp[3] = 32'h3F800000;
        for (int i = 0; i < 4; i++) begin
            apply(vy[i], vx[i]);
            total++;
            if (y_out !== vexp[i]) $display("FAIL back_to_back_%0d got %h want %h", i, y_out, vexp[i]);
            else passed++;
        end
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset   = 1'b1;
        y       = '0;
        x_shift = '0;
        @(negedge clock);
        test_reset;
        test_rounding;
        test_denormal;
        test_basic;
        test_cancel;
        test_specials;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
